// File: rtl/game_pkg.sv
// Shared game definitions used by the collision detector and its helpers.
// Contents:
//   FRAME_HZ       - display frame rate, used to size time-based defaults
//   TORPEDOS_DEF   - default number of torpedo units
//   ASTEROIDS_DEF  - default number of asteroid units
//   coll_state_t   - collision detector state: GRACE (hits ignored) or ACTIVE
package game_pkg;

  localparam int FRAME_HZ      = 60;
  localparam int TORPEDOS_DEF  = 2;
  localparam int ASTEROIDS_DEF = 8;

  typedef enum logic {
    GRACE  = 1'b0,
    ACTIVE = 1'b1
  } coll_state_t;

endpackage

// File: rtl/popcount_adder.sv
// Score update helper: counts the asteroids hit in this pulse, multiplies by
// the per-asteroid points and adds the result to the current score. The sum
// is formed four bits wider than the score so it cannot wrap, then clamped
// to SCORE_MAX.
// Ports:
//   hits       in  ASTEROIDS  asteroid hit pulse vector
//   score_in   in  SCORE_W    current score
//   score_out  out SCORE_W    saturated updated score
module popcount_adder #(
  parameter int ASTEROIDS = 8,
  parameter int POINTS    = 10,
  parameter int SCORE_MAX = 9990,
  parameter int SCORE_W   = 14
) (
  input  logic [ASTEROIDS-1:0] hits,
  input  logic [SCORE_W-1:0]   score_in,
  output logic [SCORE_W-1:0]   score_out
);

  localparam int                SUM_W    = SCORE_W + 4;
  localparam logic [SUM_W-1:0]  POINTS_W = SUM_W'(POINTS);
  localparam logic [SUM_W-1:0]  MAX_W    = SUM_W'(SCORE_MAX);

  logic [SUM_W-1:0] count;
  logic [SUM_W-1:0] sum;

  // NOTE: combinational blocks use blocking '=' so the running count is
  // updated in place on each loop iteration.
  always_comb begin
    count = '0;
    for (int j = 0; j < ASTEROIDS; j++) begin
      count = count + SUM_W'(hits[j]);
    end
    sum       = SUM_W'(score_in) + count * POINTS_W;
    score_out = (sum > MAX_W) ? MAX_W[SCORE_W-1:0] : sum[SCORE_W-1:0];
  end

endmodule

// File: rtl/collision_detector.sv
// Pixel-level collision detector for the sprite chain. Draw strobes of the
// torpedo, asteroid and ship drawers are registered, combined into a hit
// matrix and OR-accumulated over a frame. At vsync the accumulated hits are
// emitted as one-cycle pulses (suppressed during the grace period), the
// score is advanced one cycle later, and the grace/active state is updated.
// Ports:
//   clk                in  pixel clock
//   resetN             in  asynchronous active-low reset
//   vsync              in  one-cycle frame pulse
//   new_game           in  one-cycle pulse: clear score, enter grace period
//   ship_shield        in  level, suppresses ship_hit
//   torpedo_draw       in  per-torpedo Draw strobe
//   asteroid_draw      in  per-asteroid Draw strobe
//   ship_draw          in  ship Draw strobe
//   torpedo_collision  out per-torpedo pulse: hit an asteroid last frame
//   asteroid_hit       out per-asteroid pulse: hit by a torpedo last frame
//   ship_hit           out pulse: ship overlapped an asteroid last frame
//   score              out binary score, saturating
//   active             out high while collisions are being reported
module collision_detector
  import game_pkg::*;
#(
  parameter int TORPEDOS     = TORPEDOS_DEF,
  parameter int ASTEROIDS    = ASTEROIDS_DEF,
  parameter int GRACE_FRAMES = 2 * FRAME_HZ,
  parameter int POINTS       = 10,
  parameter int SCORE_MAX    = 9990,
  parameter int SCORE_W      = 14
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 vsync,
  input  logic                 new_game,
  input  logic                 ship_shield,
  input  logic [TORPEDOS-1:0]  torpedo_draw,
  input  logic [ASTEROIDS-1:0] asteroid_draw,
  input  logic                 ship_draw,
  output logic [TORPEDOS-1:0]  torpedo_collision,
  output logic [ASTEROIDS-1:0] asteroid_hit,
  output logic                 ship_hit,
  output logic [SCORE_W-1:0]   score,
  output logic                 active
);

  localparam int              GC_W       = $clog2(GRACE_FRAMES + 1);
  localparam logic [GC_W-1:0] GRACE_LOAD = GC_W'(GRACE_FRAMES);

  // Stage 1: registered draw strobes
  logic [TORPEDOS-1:0]  td_q;
  logic [ASTEROIDS-1:0] ad_q;
  logic                 sd_q;

  // NOTE: clocked state is assigned with non-blocking '<=' so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      td_q <= '0;
      ad_q <= '0;
      sd_q <= 1'b0;
    end else begin
      td_q <= torpedo_draw;
      ad_q <= asteroid_draw;
      sd_q <= ship_draw;
    end
  end

  // Stage 2: hit matrix reduced per row/column. A torpedo is hit when it
  // overlaps any asteroid; an asteroid is hit when any torpedo overlaps it.
  logic [TORPEDOS-1:0]  t_hit;
  logic [ASTEROIDS-1:0] a_hit;
  logic                 s_hit;

  assign t_hit = (|ad_q) ? td_q : '0;
  assign a_hit = (|td_q) ? ad_q : '0;
  assign s_hit = sd_q & (|ad_q);

  // Frame accumulators. At vsync they restart from the current matrix value
  // rather than zero so a hit in flight on the boundary lands in the new frame.
  logic [TORPEDOS-1:0]  t_acc;
  logic [ASTEROIDS-1:0] a_acc;
  logic                 s_acc;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      t_acc <= '0;
      a_acc <= '0;
      s_acc <= 1'b0;
    end else if (new_game) begin
      t_acc <= '0;
      a_acc <= '0;
      s_acc <= 1'b0;
    end else if (vsync) begin
      t_acc <= t_hit;
      a_acc <= a_hit;
      s_acc <= s_hit;
    end else begin
      t_acc <= t_acc | t_hit;
      a_acc <= a_acc | a_hit;
      s_acc <= s_acc | s_hit;
    end
  end

  // Grace / active state machine
  coll_state_t      state, state_d;
  logic [GC_W-1:0]  grace_cnt, grace_cnt_d;
  logic             pulse_en;
  logic             ship_pulse;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state     <= GRACE;
      grace_cnt <= GRACE_LOAD;
    end else begin
      state     <= state_d;
      grace_cnt <= grace_cnt_d;
    end
  end

  // NOTE: every signal written here gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d     = state;
    grace_cnt_d = grace_cnt;
    pulse_en    = 1'b0;
    ship_pulse  = 1'b0;
    if (new_game) begin
      state_d     = GRACE;
      grace_cnt_d = GRACE_LOAD;
    end else if (vsync) begin
      unique case (state)
        GRACE: begin
          // The vsync that ends the grace period still reports nothing.
          if (grace_cnt == GC_W'(1)) begin
            state_d = ACTIVE;
          end else begin
            grace_cnt_d = grace_cnt - 1'b1;
          end
        end
        ACTIVE: begin
          pulse_en   = 1'b1;
          ship_pulse = s_acc & ~ship_shield;
          if (ship_pulse) begin
            state_d     = GRACE;
            grace_cnt_d = GRACE_LOAD;
          end
        end
      endcase
    end
  end

  // Score update from the previous cycle's asteroid pulses
  logic [SCORE_W-1:0] score_next;

  popcount_adder #(
    .ASTEROIDS (ASTEROIDS),
    .POINTS    (POINTS),
    .SCORE_MAX (SCORE_MAX),
    .SCORE_W   (SCORE_W)
  ) u_popcount_adder (
    .hits      (asteroid_hit),
    .score_in  (score),
    .score_out (score_next)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      torpedo_collision <= '0;
      asteroid_hit      <= '0;
      ship_hit          <= 1'b0;
      score             <= '0;
    end else begin
      torpedo_collision <= pulse_en ? t_acc : '0;
      asteroid_hit      <= pulse_en ? a_acc : '0;
      ship_hit          <= ship_pulse;
      score             <= new_game ? '0 : score_next;
    end
  end

  assign active = (state == ACTIVE);

endmodule

// File: tb/tb_collision_detector.sv
// Self-checking bench for collision_detector. A history-based model keeps
// every cycle's draw inputs and, at each vsync, scans the pixels belonging
// to the closing frame to derive the pulses; a compare process checks the
// DUT against it on every falling edge. Directed scenarios add literal
// expectations.
module tb_collision_detector;

  localparam int NT   = 2;
  localparam int NA   = 8;
  localparam int GF   = 120;
  localparam int PTS  = 10;
  localparam int SMAX = 9990;
  localparam int SW   = 14;
  localparam int HN   = 8192;

  logic          clk = 1'b0;
  logic          resetN;
  logic          vsync;
  logic          new_game;
  logic          ship_shield;
  logic [NT-1:0] torpedo_draw;
  logic [NA-1:0] asteroid_draw;
  logic          ship_draw;
  logic [NT-1:0] torpedo_collision;
  logic [NA-1:0] asteroid_hit;
  logic          ship_hit;
  logic [SW-1:0] score;
  logic          active;

  always #5 clk = ~clk;

  collision_detector dut (
    .clk               (clk),
    .resetN            (resetN),
    .vsync             (vsync),
    .new_game          (new_game),
    .ship_shield       (ship_shield),
    .torpedo_draw      (torpedo_draw),
    .asteroid_draw     (asteroid_draw),
    .ship_draw         (ship_draw),
    .torpedo_collision (torpedo_collision),
    .asteroid_hit      (asteroid_hit),
    .ship_hit          (ship_hit),
    .score             (score),
    .active            (active)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [NT-1:0] h_td [HN];
  logic [NA-1:0] h_ad [HN];
  logic          h_sd [HN];
  int            cyc       = 0;
  int            win_start = 0;
  int            m_grace   = GF;
  bit            m_act     = 1'b0;
  logic [NT-1:0] e_tc      = '0;
  logic [NA-1:0] e_ah      = '0;
  logic          e_sh      = 1'b0;
  int            e_score   = 0;

  always @(posedge clk) begin : model
    int            prev_hits;
    logic [NT-1:0] ft;
    logic [NA-1:0] fa;
    logic          fs;
    prev_hits      = $countones(e_ah);
    h_td[cyc % HN] = torpedo_draw;
    h_ad[cyc % HN] = asteroid_draw;
    h_sd[cyc % HN] = ship_draw;
    if (!resetN) begin
      m_act     = 1'b0;
      m_grace   = GF;
      e_tc      = '0;
      e_ah      = '0;
      e_sh      = 1'b0;
      e_score   = 0;
      win_start = cyc + 1;
    end else begin
      e_score = e_score + PTS * prev_hits;
      if (e_score > SMAX) e_score = SMAX;
      e_tc = '0;
      e_ah = '0;
      e_sh = 1'b0;
      if (new_game) begin
        e_score   = 0;
        m_act     = 1'b0;
        m_grace   = GF;
        win_start = cyc;
      end else if (vsync) begin
        // A pixel counts for this vsync if it arrived at least two cycles
        // earlier and not before the previous frame's window opened.
        ft = '0;
        fa = '0;
        fs = 1'b0;
        for (int p = win_start; p <= cyc - 2; p++) begin
          for (int i = 0; i < NT; i++)
            for (int j = 0; j < NA; j++)
              if (h_td[p % HN][i] && h_ad[p % HN][j]) begin
                ft[i] = 1'b1;
                fa[j] = 1'b1;
              end
          if (h_sd[p % HN] && (h_ad[p % HN] != '0)) fs = 1'b1;
        end
        if (m_act) begin
          e_tc = ft;
          e_ah = fa;
          e_sh = fs && !ship_shield;
          if (e_sh) begin
            m_act   = 1'b0;
            m_grace = GF;
          end
        end else if (m_grace == 1) begin
          m_act = 1'b1;
        end else begin
          m_grace--;
        end
        win_start = cyc - 1;
      end
    end
    cyc++;
  end

  // ---------------- compare process ----------------
  bit cmp_en = 1'b0;

  always @(negedge clk) begin
    if (cmp_en) begin
      if (!resetN) begin
        check("rst_torpedo_collision", torpedo_collision, 0);
        check("rst_asteroid_hit", asteroid_hit, 0);
        check("rst_ship_hit", ship_hit, 0);
        check("rst_score", score, 0);
        check("rst_active", active, 0);
      end else begin
        check("torpedo_collision", torpedo_collision, e_tc);
        check("asteroid_hit", asteroid_hit, e_ah);
        check("ship_hit", ship_hit, e_sh);
        check("score", score, e_score);
        check("active", active, m_act);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic [NT-1:0] td, input logic [NA-1:0] ad, input logic sd,
                      input logic vs, input logic ng, input logic sh);
    torpedo_draw  = td;
    asteroid_draw = ad;
    ship_draw     = sd;
    vsync         = vs;
    new_game      = ng;
    ship_shield   = sh;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) step('0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // One overlap pixel, one idle cycle, then vsync: pixel is two cycles early.
  task automatic frame(input logic [NT-1:0] td, input logic [NA-1:0] ad);
    step(td, ad, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);
    step('0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic ship_frame(input logic sh);
    step('0, 8'h01, 1'b1, 1'b0, 1'b0, sh);
    step('0, '0, 1'b0, 1'b0, 1'b0, sh);
    step('0, '0, 1'b0, 1'b1, 1'b0, sh);
  endtask

  task automatic grace_run(input logic [NT-1:0] td, input logic [NA-1:0] ad);
    for (int k = 1; k <= GF; k++) begin
      frame(td, ad);
      check("grace_pulses", {torpedo_collision, asteroid_hit, ship_hit}, 0);
      if (k == GF - 1) check("grace_active_before_last", active, 0);
      if (k == GF)     check("grace_active_after_last", active, 1);
    end
  endtask

  initial begin
    resetN = 1'b0;
    step('0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);
    check("reset_pulses", {torpedo_collision, asteroid_hit, ship_hit}, 0);
    check("reset_score", score, 0);
    check("reset_active", active, 0);
    resetN = 1'b1;
    cmp_en = 1'b1;

    // Grace period with a torpedo 0 / asteroid 3 overlap every frame
    grace_run(2'b01, 8'h08);

    // Single 1-pixel overlap: torpedo 1 with asteroid 5
    frame(2'b10, 8'h20);
    check("t1a5_tc", torpedo_collision, 2'b10);
    check("t1a5_ah", asteroid_hit, 8'h20);
    idle(1);
    check("t1a5_score", score, 10);
    check("t1a5_pulse_gone", asteroid_hit, 0);

    // Two-torpedo pattern on separate pixels
    step(2'b01, 8'h06, 1'b0, 1'b0, 1'b0, 1'b0);
    step(2'b10, 8'h04, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);
    step('0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("multi_tc", torpedo_collision, 2'b11);
    check("multi_ah", asteroid_hit, 8'h06);
    idle(1);
    check("multi_score", score, 30);

    // Ship overlap, shielded then unshielded
    ship_frame(1'b1);
    check("shield_ship_hit", ship_hit, 0);
    check("shield_active", active, 1);
    ship_frame(1'b0);
    check("ship_hit", ship_hit, 1);
    check("ship_active_drop", active, 0);
    grace_run(2'b01, 8'h01);

    // Pixel on the cycle before vsync goes to the next frame
    step(2'b01, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    step('0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("late_pixel_not_now", torpedo_collision, 0);
    idle(1);
    step('0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("late_pixel_next_tc", torpedo_collision, 2'b01);
    check("late_pixel_next_ah", asteroid_hit, 8'h01);
    // Pixel coincident with vsync also belongs to the next frame
    step(2'b10, 8'h02, 1'b0, 1'b1, 1'b0, 1'b0);
    check("vs_pixel_not_now", asteroid_hit, 0);
    idle(1);
    step('0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("vs_pixel_next_ah", asteroid_hit, 8'h02);
    idle(1);
    check("boundary_score", score, 50);

    // Drive score toward saturation: 124 frames of 8 hits, then one hit
    for (int k = 0; k < 124; k++) frame(2'b11, 8'hFF);
    frame(2'b01, 8'h01);
    idle(1);
    check("score_9980", score, 9980);
    frame(2'b01, 8'h0C);
    idle(1);
    check("score_saturated", score, SMAX);
    frame(2'b11, 8'hFF);
    idle(1);
    check("score_stays_saturated", score, SMAX);

    // Async reset mid-frame with accumulators set
    step(2'b11, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
    #2 resetN = 1'b0;
    #1;
    check("async_rst_score", score, 0);
    check("async_rst_active", active, 0);
    check("async_rst_pulses", {torpedo_collision, asteroid_hit, ship_hit}, 0);
    @(negedge clk);
    @(negedge clk);
    resetN = 1'b1;
    grace_run('0, '0);

    // new_game coincident with vsync
    frame(2'b01, 8'h10);
    idle(1);
    check("pre_newgame_score", score, 10);
    step(2'b01, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    step(2'b10, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
    step('0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("newgame_pulses", {torpedo_collision, asteroid_hit, ship_hit}, 0);
    check("newgame_active", active, 0);
    idle(1);
    check("newgame_score", score, 0);
    grace_run('0, '0);
    frame('0, '0);
    check("after_newgame_empty", {torpedo_collision, asteroid_hit}, 0);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
